sd_sector_responder: RTL and testbench

SD_SECTOR_RESPONDER -- requirements
Module: sd_sector_responder

---
 rtl/sd_sector_responder_pkg.sv | 23 ++
 rtl/sd_sector_responder.sv | 169 ++++++++++++++++
 tb/tb_sd_sector_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_responder_pkg.sv
// Shared types and constants for the SD sector responder.
// The state enum lives here so the bench and any wrapper share one encoding.
package sd_sector_responder_pkg;

  localparam int SECTOR_WORDS    = 256;
  localparam int DEF_LBA_W       = 4;
  localparam int DEF_IMG_SECTORS = 16;

  localparam logic [7:0] LAST_INDEX = 8'(SECTOR_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ACK     = 4'd1,
    S_RD_REQ  = 4'd2,
    S_RD_PUSH = 4'd3,
    S_WR_ADDR = 4'd4,
    S_WR_CAP  = 4'd5,
    S_WR_REQ  = 4'd6,
    S_DONE    = 4'd7,
    S_GAP     = 4'd8
  } state_t;

endpackage

// File: rtl/sd_sector_responder.sv
// Serves 256-word SD sector reads/writes from an external word-addressed image.
// Out-of-range sectors read as zeros and silently discard writes.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  IDLE      | wait for sd_rd/sd_wr, latch lba, op and range flag
//  ACK       | raise sd_ack, clear word index
//  RD_REQ    | fetch word {lba,index} from backing memory (skipped if out of range)
//  RD_PUSH   | one-cycle sd_buff_wr of the fetched word
//  WR_ADDR   | present index to the initiator's sync-read buffer
//  WR_CAP    | sample sd_buff_din into mem_wdata
//  WR_REQ    | store word to backing memory (skipped if out of range)
//  DONE      | sd_ack low
//  GAP       | sd_ack held low one more cycle, requests ignored
module sd_sector_responder
  import sd_sector_responder_pkg::*;
#(
  parameter int LBA_W       = DEF_LBA_W,
  parameter int IMG_SECTORS = DEF_IMG_SECTORS
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [31:0]        sd_lba,
  input  logic               sd_rd,
  input  logic               sd_wr,
  output logic               sd_ack,
  output logic [7:0]         sd_buff_addr,
  output logic [15:0]        sd_buff_dout,
  output logic               sd_buff_wr,
  input  logic [15:0]        sd_buff_din,
  output logic [LBA_W+7:0]   mem_addr,
  output logic               mem_rd,
  output logic               mem_we,
  output logic [15:0]        mem_wdata,
  input  logic [15:0]        mem_rdata,
  input  logic               mem_ack,
  output logic               busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LBA_W-1:0]  r_lba;
  logic              r_is_rd;
  logic              r_in_range;
  logic [7:0]        r_index;
  logic [7:0]        w_index_nxt;
  logic [7:0]        r_buff_addr;
  logic [15:0]       r_rdata;
  logic [15:0]       r_wdata;

  logic              w_req;
  logic              w_lba_in_range;
  logic              w_last;
  logic              w_mem_done;
  logic              w_latch;
  logic              w_capture_rd;
  logic              w_capture_wr;
  logic              w_buff_addr_ld;

  assign w_req          = sd_rd | sd_wr;
  // Full-width compare so high lba bits cannot alias into the image.
  assign w_lba_in_range = (sd_lba < 32'(IMG_SECTORS));
  assign w_last         = (r_index == LAST_INDEX);
  assign w_mem_done     = r_in_range ? mem_ack : 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_latch      = 1'b0;
    w_capture_rd = 1'b0;
    w_capture_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_index_nxt = 8'd0;
        w_state_nxt = r_is_rd ? S_RD_REQ : S_WR_ADDR;
      end
      S_RD_REQ: begin
        if (w_mem_done) begin
          w_capture_rd = 1'b1;
          w_state_nxt  = S_RD_PUSH;
        end
      end
      S_RD_PUSH: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_index_nxt = r_index + 8'd1;
          w_state_nxt = S_RD_REQ;
        end
      end
      S_WR_ADDR: w_state_nxt = S_WR_CAP;
      S_WR_CAP: begin
        w_capture_wr = 1'b1;
        w_state_nxt  = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (w_mem_done) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_index_nxt = r_index + 8'd1;
            w_state_nxt = S_WR_ADDR;
          end
        end
      end
      S_DONE:  w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer address only moves when entering a state that presents it.
  assign w_buff_addr_ld = (w_state_nxt == S_RD_PUSH) || (w_state_nxt == S_WR_ADDR);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_lba       <= '0;
      r_is_rd     <= 1'b0;
      r_in_range  <= 1'b0;
      r_index     <= 8'd0;
      r_buff_addr <= 8'd0;
      r_rdata     <= 16'h0000;
      r_wdata     <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      if (w_latch) begin
        r_lba      <= sd_lba[LBA_W-1:0];
        r_is_rd    <= sd_rd;
        r_in_range <= w_lba_in_range;
      end
      if (w_buff_addr_ld) begin
        r_buff_addr <= w_index_nxt;
      end
      if (w_capture_rd) begin
        r_rdata <= r_in_range ? mem_rdata : 16'h0000;
      end
      if (w_capture_wr) begin
        r_wdata <= sd_buff_din;
      end
    end
  end

  // Decoded from the state register so reset drops them immediately.
  always_comb begin
    sd_ack = 1'b0;
    case (r_state)
      S_ACK, S_RD_REQ, S_RD_PUSH, S_WR_ADDR, S_WR_CAP, S_WR_REQ: sd_ack = 1'b1;
      default:                                                   sd_ack = 1'b0;
    endcase
  end

  assign sd_buff_wr   = (r_state == S_RD_PUSH);
  assign sd_buff_addr = r_buff_addr;
  assign sd_buff_dout = r_rdata;
  assign mem_addr     = {r_lba, r_index};
  assign mem_rd       = (r_state == S_RD_REQ) && r_in_range;
  assign mem_we       = (r_state == S_WR_REQ) && r_in_range;
  assign mem_wdata    = r_wdata;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed plus randomized sector transfers against a word-array image and an
// expected-transfer model built from sector/index arithmetic.
module tb_sd_sector_responder;
  import sd_sector_responder_pkg::*;

  localparam int LBA_W = 4;
  localparam int IMG   = 16;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [31:0]       sd_lba;
  logic              sd_rd, sd_wr;
  logic              sd_ack;
  logic [7:0]        sd_buff_addr;
  logic [15:0]       sd_buff_dout;
  logic              sd_buff_wr;
  logic [15:0]       sd_buff_din;
  logic [LBA_W+7:0]  mem_addr;
  logic              mem_rd, mem_we;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;
  logic              busy;

  always #5 clk_sys = ~clk_sys;

  sd_sector_responder #(.LBA_W(LBA_W), .IMG_SECTORS(IMG)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );

  typedef struct { logic [11:0] a; logic [15:0] d; } ent_t;

  logic [15:0] mem  [4096];
  logic [15:0] ibuf [256];
  ent_t        rd_q[$];
  ent_t        wr_q[$];
  int          lat = 2;
  int          lat_cnt;
  int          n_rd_cyc, n_we_cyc, n_overlap;
  int          low_run, last_low;
  logic        prev_ack;
  int          n_assert = 0;
  int          n_fail   = 0;

  // Initiator buffer with one-cycle read latency.
  always @(posedge clk_sys) sd_buff_din <= ibuf[sd_buff_addr];

  // Backing memory with programmable ack latency, plus transfer logging.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack <= 1'b0;
      lat_cnt <= 0;
    end else begin
      if (mem_rd) n_rd_cyc++;
      if (mem_we) n_we_cyc++;
      if (mem_rd && mem_we) n_overlap++;
      if (sd_buff_wr) rd_q.push_back('{{4'b0, sd_buff_addr}, sd_buff_dout});
      if (mem_we && mem_ack) begin
        wr_q.push_back('{mem_addr, mem_wdata});
        mem[mem_addr] = mem_wdata;
      end
      if (mem_ack) begin
        mem_ack <= 1'b0;
      end else if (mem_rd || mem_we) begin
        if (lat_cnt >= lat) begin
          mem_ack   <= 1'b1;
          mem_rdata <= mem[mem_addr];
          lat_cnt   <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end else begin
        lat_cnt <= 0;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (!sd_ack) low_run++;
    else begin
      if (!prev_ack) last_low = low_run;
      low_run = 0;
    end
    prev_ack = sd_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_sector(input logic rd, input logic wr, input logic [31:0] lba,
                            input bit immediate, input string tag);
    int   k;
    logic in_rng;
    logic [3:0]  l4;
    logic [15:0] exp_d;
    if (!immediate) @(negedge clk_sys);
    rd_q.delete(); wr_q.delete();
    n_rd_cyc = 0; n_we_cyc = 0;
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    k = 0;
    while (!sd_ack && k < 50) begin @(negedge clk_sys); k++; end
    check({tag, "_ack_rise"}, 32'(sd_ack), 32'd1);
    sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = $urandom;
    k = 0;
    while (sd_ack && k < 8000) begin @(negedge clk_sys); k++; end
    check({tag, "_ack_fall"}, 32'(sd_ack), 32'd0);
    in_rng = (lba < 32'(IMG));
    l4 = lba[3:0];
    if (rd) begin
      check({tag, "_npulse"}, 32'(rd_q.size()), 32'd256);
      for (int i = 0; i < rd_q.size() && i < 256; i++) begin
        exp_d = in_rng ? mem[{l4, 8'(i)}] : 16'h0000;
        check({tag, "_rd_word"}, {4'b0, rd_q[i].a, rd_q[i].d}, {4'b0, 12'(i), exp_d});
      end
      check({tag, "_rd_no_we"}, 32'(wr_q.size() + n_we_cyc), 32'd0);
      if (!in_rng) check({tag, "_oor_no_mem_rd"}, 32'(n_rd_cyc), 32'd0);
      else         check({tag, "_mem_rd_seen"}, 32'(n_rd_cyc >= 256), 32'd1);
    end else begin
      check({tag, "_nwrites"}, 32'(wr_q.size()), in_rng ? 32'd256 : 32'd0);
      for (int i = 0; i < wr_q.size() && i < 256; i++)
        check({tag, "_wr_word"}, {4'b0, wr_q[i].a, wr_q[i].d}, {4'b0, l4, 8'(i), ibuf[i]});
      check({tag, "_wr_no_rd"}, 32'(rd_q.size() + n_rd_cyc), 32'd0);
      if (!in_rng) check({tag, "_oor_no_we"}, 32'(n_we_cyc), 32'd0);
    end
  endtask

  initial begin
    int   k;
    logic op;
    reset_n = 1'b0; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
    low_run = 0; last_low = 0; prev_ack = 1'b0; n_overlap = 0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    for (int i = 0; i < 256; i++) mem[{4'd3, 8'(i)}] = {4'd0, 4'd3, 8'(i)} ^ 16'hA5A5;
    for (int i = 0; i < 256; i++) ibuf[i] = 16'(i * 3);
    #1;
    check("rst_ack",  32'(sd_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strb", {29'd0, sd_buff_wr, mem_rd, mem_we}, 32'd0);
    check("rst_addr", {12'd0, sd_buff_addr, mem_addr}, 32'd0);
    check("rst_data", {sd_buff_dout, mem_wdata}, 32'd0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;

    lat = 2;
    run_sector(1'b1, 1'b0, 32'd3, 1'b0, "rd_lba3");
    run_sector(1'b0, 1'b1, 32'd15, 1'b0, "wr_lba15");
    run_sector(1'b1, 1'b0, 32'd16, 1'b0, "rd_oor16");
    run_sector(1'b0, 1'b1, 32'h1000_0003, 1'b0, "wr_alias");
    check("alias_kept_w0", 32'(mem[12'h300]), 32'h0300 ^ 32'hA5A5);
    run_sector(1'b1, 1'b1, 32'd7, 1'b0, "both_rdwins");
    // Request already pending in DONE: DONE, GAP and IDLE are all low cycles.
    run_sector(1'b1, 1'b0, 32'd3, 1'b1, "b2b");
    check("b2b_low_cycles", 32'(last_low), 32'd3);

    for (int r = 0; r < 4; r++) begin
      op  = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 3);
      for (int i = 0; i < 256; i++) ibuf[i] = 16'($urandom);
      run_sector(op, ~op, 32'($urandom_range(0, 19)), 1'b0, "rnd");
    end

    lat = 1;
    for (int i = 0; i < 256; i++) ibuf[i] = 16'($urandom);
    @(negedge clk_sys);
    rd_q.delete(); wr_q.delete();
    sd_lba = 32'd5; sd_wr = 1'b1;
    k = 0;
    while (!sd_ack && k < 50) begin @(negedge clk_sys); k++; end
    sd_wr = 1'b0;
    k = 0;
    while (!(mem_we && mem_addr[7:0] == 8'd100) && k < 3000) begin @(negedge clk_sys); k++; end
    check("rst_mid_reach100", 32'(mem_we && mem_addr[7:0] == 8'd100), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ack",  32'(sd_ack), 32'd0);
    check("rst_mid_we",   32'(mem_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_commits", 32'(wr_q.size()), 32'd100);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("rst_mid_no_late_we", 32'(wr_q.size()), 32'd100);
    run_sector(1'b1, 1'b0, 32'd5, 1'b0, "rd_after_rst");

    check("no_rd_we_overlap", 32'(n_overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
